// File: rtl/mips_mem_responder_pkg.sv
// Shared types for the MIPS memory responder: address/data words, FSM states
// and the wait-state counter type.
package mips_mem_responder_pkg;

  typedef logic [31:0] mips_pc_t;
  typedef logic [31:0] mips_data_t;

  typedef enum logic [1:0] {MEM_IDLE, MEM_WAIT, MEM_RESP} mips_mem_state_t;

  localparam int MIPS_MEM_MAX_WAIT = 15;

  typedef logic [3:0] mips_mem_wait_t;

endpackage

// File: rtl/mips_mem_responder_array.sv
// Synchronous single-port word RAM; read data is registered on the enable edge
// and the contents are never reset.
import mips_mem_responder_pkg::*;

module mips_mem_array #(
  parameter int MEM_DEPTH_WORDS = 256,
  parameter int IDX_W           = $clog2(MEM_DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             en,
  input  logic             we,
  input  logic [IDX_W-1:0] index,
  input  mips_data_t       wdata,
  output mips_data_t       rdata
);

  mips_data_t mem_q [MEM_DEPTH_WORDS];
  mips_data_t rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem_q[index] <= wdata;
      end
      rdata_q <= mem_q[index];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mips_mem_responder.sv
// Memory responder for the multi-cycle MIPS core: one request at a time,
// WAIT_CYCLES wait states, then the array access and a held response.
import mips_mem_responder_pkg::*;

module mips_mem_responder #(
  parameter int MEM_DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES     = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_we,
  input  mips_pc_t   req_addr,
  input  mips_data_t req_wdata,
  output logic       resp_valid,
  input  logic       resp_ready,
  output mips_data_t resp_rdata,
  output logic       resp_err,
  output logic       busy
);

  localparam int IDX_W = $clog2(MEM_DEPTH_WORDS);

  mips_mem_state_t state_q;
  mips_mem_wait_t  cnt_q;
  logic            we_q;
  mips_pc_t        addr_q;
  mips_data_t      wdata_q;
  logic            rd_ok_q;
  logic            err_q;
  logic            req_ready_q;
  logic            resp_valid_q;
  logic            busy_q;

  logic            access;
  logic            addr_err;
  logic            arr_en;
  mips_data_t      arr_rdata;

  // Word index is compared at full width so high address bits never alias.
  assign addr_err = (addr_q[1:0] != 2'b00) ||
                    ({2'b00, addr_q[31:2]} >= 32'(MEM_DEPTH_WORDS));
  assign access   = (state_q == MEM_WAIT) && (cnt_q == '0);
  assign arr_en   = access && !addr_err;

  mips_mem_array #(
    .MEM_DEPTH_WORDS (MEM_DEPTH_WORDS),
    .IDX_W           (IDX_W)
  ) u_array (
    .clk   (clk),
    .en    (arr_en),
    .we    (we_q),
    .index (addr_q[IDX_W+1:2]),
    .wdata (wdata_q),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= MEM_IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rd_ok_q      <= 1'b0;
      err_q        <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        MEM_IDLE: begin
          if (req_valid) begin
            we_q        <= req_we;
            addr_q      <= req_addr;
            wdata_q     <= req_wdata;
            cnt_q       <= mips_mem_wait_t'(WAIT_CYCLES);
            state_q     <= MEM_WAIT;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        MEM_WAIT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            state_q      <= MEM_RESP;
            resp_valid_q <= 1'b1;
            err_q        <= addr_err;
            rd_ok_q      <= !addr_err && !we_q;
          end
        end
        MEM_RESP: begin
          if (resp_ready) begin
            state_q      <= MEM_IDLE;
            resp_valid_q <= 1'b0;
            err_q        <= 1'b0;
            rd_ok_q      <= 1'b0;
            req_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
          end
        end
        default: state_q <= MEM_IDLE;
      endcase
    end
  end

  // The RAM output register holds its value until the next enable, so gating
  // it with rd_ok_q gives a stable response that reads 0 for writes/errors.
  assign resp_rdata = rd_ok_q ? arr_rdata : '0;
  assign resp_err   = err_q;
  assign resp_valid = resp_valid_q;
  assign req_ready  = req_ready_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_mips_mem_responder.sv
// Directed self-checking bench for mips_mem_responder: one instance with two
// wait states and one with zero wait states, selected onto shared probes.
module tb_mips_mem_responder;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        sel = 1'b0;
  logic        reqValid = 1'b0;
  logic        reqWe = 1'b0;
  logic [31:0] reqAddr = '0;
  logic [31:0] reqWdata = '0;
  logic        respReady = 1'b0;

  logic        reqReadyA, respValidA, respErrA, busyA;
  logic [31:0] respRdataA;
  logic        reqReadyB, respValidB, respErrB, busyB;
  logic [31:0] respRdataB;
  logic        reqValidA, reqValidB;

  logic        reqReady, respValid, respErr, busy;
  logic [31:0] respRdata;

  int assertCount = 0;
  int failCount   = 0;

  always #5 clk = ~clk;

  assign reqValidA = reqValid && !sel;
  assign reqValidB = reqValid && sel;
  assign reqReady  = sel ? reqReadyB  : reqReadyA;
  assign respValid = sel ? respValidB : respValidA;
  assign respErr   = sel ? respErrB   : respErrA;
  assign busy      = sel ? busyB      : busyA;
  assign respRdata = sel ? respRdataB : respRdataA;

  mips_mem_responder #(.MEM_DEPTH_WORDS(256), .WAIT_CYCLES(2)) dutA (
    .clk(clk), .rst_n(rstN), .req_valid(reqValidA), .req_ready(reqReadyA),
    .req_we(reqWe), .req_addr(reqAddr), .req_wdata(reqWdata),
    .resp_valid(respValidA), .resp_ready(respReady), .resp_rdata(respRdataA),
    .resp_err(respErrA), .busy(busyA)
  );

  mips_mem_responder #(.MEM_DEPTH_WORDS(256), .WAIT_CYCLES(0)) dutB (
    .clk(clk), .rst_n(rstN), .req_valid(reqValidB), .req_ready(reqReadyB),
    .req_we(reqWe), .req_addr(reqAddr), .req_wdata(reqWdata),
    .resp_valid(respValidB), .resp_ready(respReady), .resp_rdata(respRdataB),
    .resp_err(respErrB), .busy(busyB)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One full transaction with resp_ready held high; lat counts edges from
  // acceptance until resp_valid is seen (bounded).
  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                               output logic [31:0] rdata, output logic err, output int lat);
    @(negedge clk);
    reqWe = we; reqAddr = addr; reqWdata = wdata; reqValid = 1'b1; respReady = 1'b1;
    @(posedge clk); #1;
    reqValid = 1'b0;
    lat = 0;
    while (!respValid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    rdata = respRdata;
    err   = respErr;
    @(posedge clk); #1;
  endtask

  task automatic waitResp(output int n);
    n = 0;
    while (!respValid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          n;
    logic        flag;
    logic        prevBusy;
    int          nAcc, nResp;
    int          accCyc [3];
    int          respCyc [3];
    logic [31:0] respData [3];
    logic [31:0] expWords [3];

    for (int i = 0; i < 3; i++) begin
      accCyc[i] = 0; respCyc[i] = 0; respData[i] = '0;
    end
    expWords[0] = 32'h1111_1111;
    expWords[1] = 32'h2222_2222;
    expWords[2] = 32'h3333_3333;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_req_ready", 32'(reqReady), 32'd1);
    checkOutput("rst_resp_valid", 32'(respValid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_rdata", respRdata, 32'd0);
    checkOutput("rst_err", 32'(respErr), 32'd0);
    @(negedge clk);
    rstN = 1'b1;

    // Detailed latency check on the first write.
    @(negedge clk);
    reqWe = 1'b1; reqAddr = 32'h10; reqWdata = 32'hDEAD_BEEF; reqValid = 1'b1; respReady = 1'b0;
    @(posedge clk); #1;
    reqValid = 1'b0;
    checkOutput("wr_ready_low_1", 32'(reqReady), 32'd0);
    checkOutput("wr_busy_1", 32'(busy), 32'd1);
    @(posedge clk); #1;
    checkOutput("wr_valid_t1", 32'(respValid), 32'd0);
    @(posedge clk); #1;
    checkOutput("wr_valid_t2", 32'(respValid), 32'd0);
    checkOutput("wr_ready_low_3", 32'(reqReady), 32'd0);
    @(posedge clk); #1;
    checkOutput("wr_valid_t3", 32'(respValid), 32'd1);
    checkOutput("wr_rdata", respRdata, 32'd0);
    checkOutput("wr_err", 32'(respErr), 32'd0);
    respReady = 1'b1;
    @(posedge clk); #1;
    checkOutput("wr_hs_valid", 32'(respValid), 32'd0);
    checkOutput("wr_hs_busy", 32'(busy), 32'd0);
    checkOutput("wr_hs_ready", 32'(reqReady), 32'd1);

    applyStimulus(1'b0, 32'h10, 32'h0, rd, er, lat);
    checkOutput("rd10_data", rd, 32'hDEAD_BEEF);
    checkOutput("rd10_err", 32'(er), 32'd0);
    checkOutput("rd10_lat", 32'(lat), 32'd3);

    applyStimulus(1'b0, 32'h12, 32'h0, rd, er, lat);
    checkOutput("mis_err", 32'(er), 32'd1);
    checkOutput("mis_rdata", rd, 32'd0);
    applyStimulus(1'b1, 32'h11, 32'hFFFF_FFFF, rd, er, lat);
    checkOutput("mis_wr_err", 32'(er), 32'd1);
    applyStimulus(1'b0, 32'h10, 32'h0, rd, er, lat);
    checkOutput("mis_unchanged", rd, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 32'h400, 32'h0, rd, er, lat);
    checkOutput("oor_err", 32'(er), 32'd1);
    checkOutput("oor_rdata", rd, 32'd0);
    applyStimulus(1'b1, 32'h8000_0010, 32'h0BAD_0BAD, rd, er, lat);
    checkOutput("oor_hi_err", 32'(er), 32'd1);
    applyStimulus(1'b0, 32'h10, 32'h0, rd, er, lat);
    checkOutput("oor_no_alias", rd, 32'hDEAD_BEEF);
    applyStimulus(1'b1, 32'h3FC, 32'hCAFE_F00D, rd, er, lat);
    checkOutput("last_wr_err", 32'(er), 32'd0);
    applyStimulus(1'b0, 32'h3FC, 32'h0, rd, er, lat);
    checkOutput("last_rd_data", rd, 32'hCAFE_F00D);
    checkOutput("last_rd_err", 32'(er), 32'd0);

    // Response stall with a competing request held on the request port.
    @(negedge clk);
    reqWe = 1'b0; reqAddr = 32'h10; reqValid = 1'b1; respReady = 1'b0;
    @(posedge clk); #1;
    reqValid = 1'b0;
    waitResp(n);
    checkOutput("stall_reached", 32'(respValid), 32'd1);
    reqWe = 1'b1; reqAddr = 32'h30; reqWdata = 32'h0000_0055; reqValid = 1'b1;
    flag = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (!respValid || respRdata !== 32'hDEAD_BEEF || respErr || reqReady) flag = 1'b0;
    end
    checkOutput("stall_stable", 32'(flag), 32'd1);
    respReady = 1'b1;
    @(posedge clk); #1;
    checkOutput("stall_hs_valid", 32'(respValid), 32'd0);
    checkOutput("stall_hs_ready", 32'(reqReady), 32'd1);
    checkOutput("stall_hs_rdata", respRdata, 32'd0);
    checkOutput("stall_hs_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    checkOutput("stall_next_accept", 32'(busy), 32'd1);
    reqValid = 1'b0;
    waitResp(n);
    @(posedge clk); #1;
    applyStimulus(1'b0, 32'h30, 32'h0, rd, er, lat);
    checkOutput("stall_wr_commit", rd, 32'h0000_0055);

    // Reset during WAIT aborts the pending write.
    applyStimulus(1'b1, 32'h20, 32'h0BAD_C0DE, rd, er, lat);
    @(negedge clk);
    reqWe = 1'b1; reqAddr = 32'h20; reqWdata = 32'h1234_5678; reqValid = 1'b1; respReady = 1'b1;
    @(posedge clk); #1;
    reqValid = 1'b0;
    rstN = 1'b0;
    #2;
    checkOutput("rstw_busy", 32'(busy), 32'd0);
    checkOutput("rstw_ready", 32'(reqReady), 32'd1);
    @(negedge clk);
    rstN = 1'b1;
    flag = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (respValid || busy) flag = 1'b0;
    end
    checkOutput("rstw_no_resp", 32'(flag), 32'd1);
    applyStimulus(1'b0, 32'h20, 32'h0, rd, er, lat);
    checkOutput("rstw_old_value", rd, 32'h0BAD_C0DE);

    // Reset during RESP drops the response but keeps the committed write.
    @(negedge clk);
    reqWe = 1'b1; reqAddr = 32'h40; reqWdata = 32'hA5A5_5A5A; reqValid = 1'b1; respReady = 1'b0;
    @(posedge clk); #1;
    reqValid = 1'b0;
    waitResp(n);
    rstN = 1'b0;
    #2;
    checkOutput("rstr_valid", 32'(respValid), 32'd0);
    @(negedge clk);
    rstN = 1'b1;
    applyStimulus(1'b0, 32'h40, 32'h0, rd, er, lat);
    checkOutput("rstr_kept", rd, 32'hA5A5_5A5A);

    // Zero wait states: preload then back-to-back reads.
    sel = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'(i * 4), expWords[i], rd, er, lat);
      checkOutput($sformatf("w0_wr%0d_lat", i), 32'(lat), 32'd1);
    end
    @(negedge clk);
    reqWe = 1'b0; reqAddr = 32'h0; reqValid = 1'b1; respReady = 1'b1;
    prevBusy = 1'b0; nAcc = 0; nResp = 0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (busy && !prevBusy && nAcc < 3) begin
        accCyc[nAcc] = c;
        nAcc++;
        if (nAcc == 3) reqValid = 1'b0;
        else reqAddr = 32'(nAcc * 4);
      end
      if (respValid && nResp < 3) begin
        respCyc[nResp]  = c;
        respData[nResp] = respRdata;
        nResp++;
      end
      prevBusy = busy;
    end
    checkOutput("b2b_accepts", 32'(nAcc), 32'd3);
    checkOutput("b2b_resps", 32'(nResp), 32'd3);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("b2b_data%0d", i), respData[i], expWords[i]);
      checkOutput($sformatf("b2b_lat%0d", i), 32'(respCyc[i] - accCyc[i]), 32'd1);
    end
    checkOutput("b2b_gap01", 32'(accCyc[1] - accCyc[0]), 32'd3);
    checkOutput("b2b_gap12", 32'(accCyc[2] - accCyc[1]), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/mips_mem_responder.md
# mips_mem_responder

Memory-side responder for the multi-cycle MIPS core's unified instruction/data memory port. Accepts one read or write request at a time over a valid/ready handshake and holds it for a fixed, parameterised number of wait states. It then commits the access to an internal word-addressed array and returns a response over a second valid/ready handshake. It sits between the core's memory-interface FSM and the storage, and lets the core's multi-cycle controller be exercised against realistic memory latency.

## Interface
- MEM_DEPTH_WORDS, 256: number of 32-bit words in the array; power of two, ≥ 2.
- WAIT_CYCLES, 2: wait states between request acceptance and array access; 0..15.
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  reset; asynchronous and active-low.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  mips_pc_t (32)  byte address.
- req_wdata  in  mips_data_t (32)  write data.
- resp_valid  out  1  response present.
- resp_ready  in  1  core accepts the response.
- resp_rdata  out  mips_data_t (32)  read data; 0 for writes and errors.
- resp_err  out  1  access rejected: misaligned or out of range.
- busy  out  1  a request is held, i.e. state ≠ IDLE.

## Operation
- FSM states are IDLE, WAIT and RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch we, addr and wdata, load cnt=WAIT_CYCLES, and go to WAIT.
- WAIT:
  - req_ready=0.
  - If cnt≠0, decrement cnt.
  - If cnt==0, perform the access on this edge and go to RESP.
  - Access, reads: resp_rdata ← mem[addr[31:2]].
  - Access, writes: mem[addr[31:2]] ← wdata and resp_rdata ← 0.
- Error check at access:
  - Error condition: addr[1:0]≠0 or addr[31:2] ≥ MEM_DEPTH_WORDS.
  - On error: no array access, resp_err ← 1, resp_rdata ← 0.
- RESP:
  - resp_valid=1, and resp_rdata and resp_err are held stable.
  - On resp_ready, go to IDLE and clear resp_valid.
  - resp_rdata and resp_err are cleared to 0 on that exit edge.
- Only one transaction is outstanding. The earliest next acceptance is the cycle after the response handshake.
- Requests presented while not in IDLE are ignored and not queued. The requester must hold req_valid and the request fields until req_ready.
- The write is committed only at the access edge, never earlier.

## Timing
- Reset values: state=IDLE, cnt=0, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, busy=0.
- Array contents are not reset and keep their values across rst_n.
- Latency: a request accepted at edge t0 produces resp_valid visible after edge t0+WAIT_CYCLES+1. With WAIT_CYCLES=0 this is the next edge.
- busy rises after t0 and falls after the response handshake edge.
- Throughput: at most one transaction per WAIT_CYCLES+3 cycles when resp_ready is held high.
- resp_ready held high before resp_valid rises: the handshake completes on the first RESP cycle.
- req_valid and resp_ready both high in RESP: only the response completes. The new request is accepted in IDLE one cycle later.
- Reset asserted in WAIT: the transaction is aborted; the pending write is not committed and no response is produced.
- Reset asserted in RESP: the response is dropped. An already-committed write stays in the array.
- Width rules:
  - Word index is addr[31:2] compared against MEM_DEPTH_WORDS at full width, with no wrap-around.
  - cnt is 4 bits.

## Structure
- Add to MIPS_pkg:
  - typedef enum logic[1:0] {MEM_IDLE, MEM_WAIT, MEM_RESP} mips_mem_state_t.
  - parameter MIPS_MEM_MAX_WAIT = 15.
  - typedef logic[3:0] mips_mem_wait_t.
- Sub-module mips_mem_array: synchronous single-port RAM, MEM_DEPTH_WORDS×32.
  - Ports: clk, en, we, index, wdata, rdata.
  - Read data is registered on the enable edge; no reset.
- The responder FSM, counter and error check live in mips_mem_responder.

## Test plan
- Reset, then write 0xDEADBEEF to 0x00000010 with WAIT_CYCLES=2 → req_ready=0 for 3 cycles; resp_valid after edge t0+3; resp_rdata=0, resp_err=0. A subsequent read of 0x10 → 0xDEADBEEF.
- Read 0x00000012 (misaligned) → resp_err=1, resp_rdata=0, array unchanged. Read 0x00000400 with depth 256 → resp_err=1.
- Hold resp_ready=0 for 5 cycles in RESP → resp_valid, resp_rdata and resp_err stable. A competing req_valid during that time is not accepted; it is accepted one cycle after the handshake.
- Write 0x12345678 to 0x20, then pulse rst_n low during WAIT → no response. A read of 0x20 after reset → the old value, not 0x12345678.
- WAIT_CYCLES=0, back-to-back reads of 0x0, 0x4, 0x8 with resp_ready=1 → each response on the edge after acceptance, one transaction per 3 cycles, data matching the preloaded words.
